// File: rtl/rf_wb_pkg.sv
// rtl/rf_wb_pkg.sv - shared widths and entry type for the register-file write-back queue
// Purpose: register-address width, default data width and the queued-entry record.
// Ports: none (package).
package rf_wb_pkg;
  localparam int XLEN   = 32;
  localparam int REG_AW = 5;

  // One queued long-latency result. v=0 marks an entry superseded by a younger ALU write.
  typedef struct packed {
    logic              v;
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   d;
  } wb_entry_t;
endpackage

// File: rtl/rf_wb_fifo.sv
// rtl/rf_wb_fifo.sv - long-latency result FIFO with rd kill and youngest-match lookup
// Purpose: holds pending long-latency results, clears valid bits on a younger write to the
//          same register, and answers two bypass lookups against the youngest live entry.
// Ports:
//   clk_i, rst_i             clock, asynchronous active-high reset
//   push_i/push_rd_i/push_data_i   enqueue a result (caller guarantees not full)
//   pop_i                    drop the head entry (caller guarantees not empty)
//   kill_i/kill_rd_i         clear valid on every entry (incl. one pushed now) with this rd
//   full_o, empty_o          occupancy flags
//   head_v_o/head_rd_o/head_data_o  head entry
//   look1_addr_i/look2_addr_i -> hit1_o/data1_o, hit2_o/data2_o   bypass lookups
module rf_wb_fifo
  import rf_wb_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              push_i,
  input  logic [REG_AW-1:0] push_rd_i,
  input  logic [XLEN-1:0]   push_data_i,
  input  logic              pop_i,
  input  logic              kill_i,
  input  logic [REG_AW-1:0] kill_rd_i,
  output logic              full_o,
  output logic              empty_o,
  output logic              head_v_o,
  output logic [REG_AW-1:0] head_rd_o,
  output logic [XLEN-1:0]   head_data_o,
  input  logic [REG_AW-1:0] look1_addr_i,
  input  logic [REG_AW-1:0] look2_addr_i,
  output logic              hit1_o,
  output logic [XLEN-1:0]   data1_o,
  output logic              hit2_o,
  output logic [XLEN-1:0]   data2_o
);
  localparam int AW = $clog2(DEPTH);

  // Pointers carry one extra bit so full and empty are distinguishable.
  logic [AW:0]       wr_ptr_q, rd_ptr_q;
  logic [AW:0]       count;
  logic              v_q  [DEPTH];
  logic [REG_AW-1:0] rd_q [DEPTH];
  logic [XLEN-1:0]   d_q  [DEPTH];

  assign count       = wr_ptr_q - rd_ptr_q;
  assign full_o      = (count == (AW+1)'(DEPTH));
  assign empty_o     = (count == '0);
  assign head_v_o    = v_q[rd_ptr_q[AW-1:0]];
  assign head_rd_o   = rd_q[rd_ptr_q[AW-1:0]];
  assign head_data_o = d_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) v_q[i] <= 1'b0;
    end else begin
      if (kill_i) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (rd_q[i] == kill_rd_i) v_q[i] <= 1'b0;
        end
      end
      // The pushed slot is never live, so this overrides the kill loop safely;
      // a same-cycle younger ALU write to the same rd kills it on arrival.
      if (push_i) begin
        v_q[wr_ptr_q[AW-1:0]] <= !(kill_i && (kill_rd_i == push_rd_i));
        wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
      end
      if (pop_i) rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
    end
  end

  // Payload needs no reset: it is only observed through valid bits.
  always_ff @(posedge clk_i) begin
    if (push_i) begin
      rd_q[wr_ptr_q[AW-1:0]] <= push_rd_i;
      d_q[wr_ptr_q[AW-1:0]]  <= push_data_i;
    end
  end

  // Scan oldest to youngest so the last match (the youngest) wins.
  function automatic logic [XLEN:0] lookup(input logic [REG_AW-1:0] addr);
    logic [XLEN:0] r;
    logic [AW-1:0] s;
    r = '0;
    for (int i = 0; i < DEPTH; i++) begin
      s = rd_ptr_q[AW-1:0] + AW'(i);
      if (((AW+1)'(i) < count) && v_q[s] && (rd_q[s] == addr) && (addr != '0))
        r = {1'b1, d_q[s]};
    end
    return r;
  endfunction

  always_comb begin
    {hit1_o, data1_o} = lookup(look1_addr_i);
    {hit2_o, data2_o} = lookup(look2_addr_i);
  end
endmodule

// File: rtl/rf_writeback_queue.sv
// rtl/rf_writeback_queue.sv - register-file write-port arbiter for ALU and long-latency results
// Purpose: sole driver of the register-file write port. ALU results win the port unless the
//          long-latency FIFO head has been passed over STARVE_MAX times; decode gets a bypass
//          of pending values.
// Ports:
//   clk, reset                      clock, asynchronous active-high reset
//   alu_valid/alu_ready/alu_rd/alu_data   ALU result handshake (never buffered)
//   lu_valid/lu_ready/lu_rd/lu_data       long-latency result handshake (buffered)
//   wb_en/wb_addr/wb_data           registered register-file write port
//   rd_addr1/rd_addr2 -> fwd1_hit/fwd1_data, fwd2_hit/fwd2_data   read bypass
//   lu_pending                      FIFO non-empty
module rf_writeback_queue
  import rf_wb_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter int STARVE_MAX = 3,
  parameter int XLEN       = rf_wb_pkg::XLEN
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              alu_valid,
  output logic              alu_ready,
  input  logic [REG_AW-1:0] alu_rd,
  input  logic [XLEN-1:0]   alu_data,
  input  logic              lu_valid,
  output logic              lu_ready,
  input  logic [REG_AW-1:0] lu_rd,
  input  logic [XLEN-1:0]   lu_data,
  output logic              wb_en,
  output logic [REG_AW-1:0] wb_addr,
  output logic [XLEN-1:0]   wb_data,
  input  logic [REG_AW-1:0] rd_addr1,
  input  logic [REG_AW-1:0] rd_addr2,
  output logic              fwd1_hit,
  output logic [XLEN-1:0]   fwd1_data,
  output logic              fwd2_hit,
  output logic [XLEN-1:0]   fwd2_data,
  output logic              lu_pending
);
  localparam int SW = $clog2(STARVE_MAX + 1);

  logic [SW-1:0]     starve_q, starve_d;
  logic              wb_en_q, wb_en_d;
  logic [REG_AW-1:0] wb_addr_q, wb_addr_d;
  logic [XLEN-1:0]   wb_data_q, wb_data_d;

  logic              alu_win, alu_wr, lu_push, pop;
  logic              f_full, f_empty, f_head_v, f_hit1, f_hit2;
  logic [REG_AW-1:0] f_head_rd;
  logic [XLEN-1:0]   f_head_d, f_data1, f_data2;

  rf_wb_fifo #(.DEPTH(DEPTH), .XLEN(XLEN)) u_fifo (
    .clk_i        (clk),
    .rst_i        (reset),
    .push_i       (lu_push),
    .push_rd_i    (lu_rd),
    .push_data_i  (lu_data),
    .pop_i        (pop),
    .kill_i       (alu_wr),
    .kill_rd_i    (alu_rd),
    .full_o       (f_full),
    .empty_o      (f_empty),
    .head_v_o     (f_head_v),
    .head_rd_o    (f_head_rd),
    .head_data_o  (f_head_d),
    .look1_addr_i (rd_addr1),
    .look2_addr_i (rd_addr2),
    .hit1_o       (f_hit1),
    .data1_o      (f_data1),
    .hit2_o       (f_hit2),
    .data2_o      (f_data2)
  );

  always_comb begin
    alu_ready = (starve_q != SW'(STARVE_MAX));
    lu_ready  = !f_full;
    alu_win   = alu_valid && alu_ready;
    // rd==0 transfers complete their handshake but produce no write or enqueue.
    alu_wr    = alu_win && (alu_rd != '0);
    lu_push   = lu_valid && lu_ready && (lu_rd != '0);
    pop       = !alu_win && !f_empty;

    wb_en_d   = 1'b0;
    wb_addr_d = wb_addr_q;
    wb_data_d = wb_data_q;
    if (alu_wr) begin
      wb_en_d   = 1'b1;
      wb_addr_d = alu_rd;
      wb_data_d = alu_data;
    end else if (pop && f_head_v) begin
      wb_en_d   = 1'b1;
      wb_addr_d = f_head_rd;
      wb_data_d = f_head_d;
    end

    // alu_win implies starve_q < STARVE_MAX, so the increment cannot overflow.
    starve_d = starve_q;
    if (pop)                      starve_d = '0;
    else if (alu_win && !f_empty) starve_d = starve_q + SW'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      starve_q  <= '0;
      wb_en_q   <= 1'b0;
      wb_addr_q <= '0;
      wb_data_q <= '0;
    end else begin
      starve_q  <= starve_d;
      wb_en_q   <= wb_en_d;
      wb_addr_q <= wb_addr_d;
      wb_data_q <= wb_data_d;
    end
  end

  assign wb_en      = wb_en_q;
  assign wb_addr    = wb_addr_q;
  assign wb_data    = wb_data_q;
  assign lu_pending = !f_empty;

  // FIFO entries are younger than whatever sits in the wb stage, so they take priority.
  always_comb begin
    fwd1_hit  = f_hit1;
    fwd1_data = f_data1;
    if (!f_hit1 && wb_en_q && (wb_addr_q == rd_addr1) && (rd_addr1 != '0)) begin
      fwd1_hit  = 1'b1;
      fwd1_data = wb_data_q;
    end
    fwd2_hit  = f_hit2;
    fwd2_data = f_data2;
    if (!f_hit2 && wb_en_q && (wb_addr_q == rd_addr2) && (rd_addr2 != '0)) begin
      fwd2_hit  = 1'b1;
      fwd2_data = wb_data_q;
    end
  end
endmodule
